control_sequencer: RTL and testbench

- Hardwired Moore control unit that sequences the 32-bit bus datapath: register file, Y, Z, HI/LO, PC, IR, MAR/MDR.
- Runs fetch (T0-T2) and then a per-opcode execute sequence, one step per clock.
- Waits on a memory-ready handshake during each memory access.
- Halts on halt, Stop, or a memory timeout.

---
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bus between the hardwired control unit and the 32-bit datapath it sequences.
// Handshake: during a memory step the sequencer holds Read/Write high and the same
// step until MemReady=1 is seen at a rising Clock edge; that edge completes the access.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        MemReady;
  logic        Stop;

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic Zhighout, Zlowout, HIin, HIout, LOin, LOout;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [4:0] alu_op;
  logic       Run;
  logic       Fault;
  logic [3:0] step;

  modport master (
    input  IR, MemReady, Stop,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
    output Zhighout, Zlowout, HIin, HIout, LOin, LOout,
    output Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output alu_op, Run, Fault, step
  );

  modport slave (
    output IR, MemReady, Stop,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
    input  Zhighout, Zlowout, HIin, HIout, LOin, LOout,
    input  Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  alu_op, Run, Fault, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, per-opcode execute T3-T7, memory
// waits with timeout, and a sticky HALT state left only through Clear.
module control_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       fault_q, fault_nx;

  logic [4:0] opcode;
  logic       op_ld, op_ldi, op_st, op_alu, op_imm, op_muldiv, op_unary;
  logic       op_mfhi, op_mflo, op_nop, op_halt, op_legal;
  logic       mem_step, last_step;
  logic       ir_unused;

  assign opcode    = bus.IR[31:27];
  assign ir_unused = ^bus.IR[26:0];

  assign op_ld     = (opcode == OP_LD);
  assign op_ldi    = (opcode == OP_LDI);
  assign op_st     = (opcode == OP_ST);
  assign op_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
  assign op_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign op_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign op_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign op_mfhi   = (opcode == OP_MFHI);
  assign op_mflo   = (opcode == OP_MFLO);
  assign op_nop    = (opcode == OP_NOP);
  assign op_halt   = (opcode == OP_HALT);
  assign op_legal  = op_ld | op_ldi | op_st | op_alu | op_imm | op_muldiv | op_unary |
                     op_mfhi | op_mflo | op_nop | op_halt;

  assign mem_step  = (state == S_T1) || (state == S_T6 && op_ld) || (state == S_T7 && op_st);

  // Final step of each instruction class: the only place Stop is honoured.
  assign last_step = (state == S_T3 && (op_mfhi || op_mflo || op_nop)) ||
                     (state == S_T4 && op_unary) ||
                     (state == S_T5 && (op_alu || op_imm || op_ldi)) ||
                     (state == S_T6 && op_muldiv) ||
                     (state == S_T7 && (op_ld || op_st));

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state    <= S_T0;
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      fault_q  <= fault_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = 8'd0;
    fault_nx    = fault_q;
    if (state == S_HALT) begin
      state_nx = S_HALT;
    end else if (mem_step && !bus.MemReady) begin
      if (wait_cnt == WAIT_LAST) begin
        state_nx = S_HALT;
        fault_nx = 1'b1;
      end else begin
        wait_cnt_nx = wait_cnt + 8'd1;
      end
    end else if (state == S_T3 && (op_halt || !op_legal)) begin
      state_nx = S_HALT;
    end else if (last_step) begin
      state_nx = bus.Stop ? S_HALT : S_T0;
    end else begin
      case (state)
        S_T0:    state_nx = S_T1;
        S_T1:    state_nx = S_T2;
        S_T2:    state_nx = S_T3;
        S_T3:    state_nx = S_T4;
        S_T4:    state_nx = S_T5;
        S_T5:    state_nx = S_T6;
        S_T6:    state_nx = S_T7;
        default: state_nx = S_T0;
      endcase
    end
  end

  // Strobes are forced low while Clear is held, even though the state already reads T0.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.HIin     = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOin     = 1'b0;
    bus.LOout    = 1'b0;
    bus.Read     = 1'b0;
    bus.Write    = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.BAout    = 1'b0;
    bus.Cout     = 1'b0;
    bus.alu_op   = 5'd0;
    if (!Clear) begin
      case (state)
        S_T0: begin
          bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        end
        S_T1: begin
          bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        end
        S_T2: begin
          bus.MDRout = 1'b1; bus.IRin = 1'b1;
        end
        S_T3: begin
          if (op_ld || op_ldi || op_st) begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
          end else if (op_alu || op_imm) begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end else if (op_muldiv) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end else if (op_unary) begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode;
          end else if (op_mfhi) begin
            bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end else if (op_mflo) begin
            bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
        end
        S_T4: begin
          if (op_ld || op_ldi || op_st) begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD;
          end else if (op_alu) begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode;
          end else if (op_imm) begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode;
          end else if (op_muldiv) begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode;
          end else if (op_unary) begin
            bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
        end
        S_T5: begin
          if (op_alu || op_imm || op_ldi) begin
            bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end else if (op_ld || op_st) begin
            bus.Zlowout = 1'b1; bus.MARin = 1'b1;
          end else if (op_muldiv) begin
            bus.Zlowout = 1'b1; bus.LOin = 1'b1;
          end
        end
        S_T6: begin
          if (op_ld) begin
            bus.Read = 1'b1; bus.MDRin = 1'b1;
          end else if (op_st) begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
          end else if (op_muldiv) begin
            bus.Zhighout = 1'b1; bus.HIin = 1'b1;
          end
        end
        S_T7: begin
          if (op_ld) begin
            bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end else if (op_st) begin
            bus.Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Run   = (state != S_HALT);
  assign bus.step  = (state == S_HALT) ? 4'd0 : 4'(state);
  assign bus.Fault = fault_q;

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      assert ($countones({bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Rout,
                          bus.HIout, bus.LOout, bus.Cout, bus.BAout}) <= 1);
      assert (!(bus.Read && bus.Write));
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction is expanded into the
// cycle-by-cycle list of expected outputs and replayed against the DUT.
module tb_control_sequencer;
  localparam int WAIT_LIMIT = 15;

  typedef logic [34:0] vec_t;  // {Fault, Run, step[3:0], alu_op[4:0], strobes[23:0]}

  localparam logic [23:0] PCOUT    = 24'h000001;
  localparam logic [23:0] PCIN     = 24'h000002;
  localparam logic [23:0] INCPC    = 24'h000004;
  localparam logic [23:0] MARIN    = 24'h000008;
  localparam logic [23:0] MDRIN    = 24'h000010;
  localparam logic [23:0] MDROUT   = 24'h000020;
  localparam logic [23:0] IRIN     = 24'h000040;
  localparam logic [23:0] YIN      = 24'h000080;
  localparam logic [23:0] ZIN      = 24'h000100;
  localparam logic [23:0] ZHIGHOUT = 24'h000200;
  localparam logic [23:0] ZLOWOUT  = 24'h000400;
  localparam logic [23:0] HIIN     = 24'h000800;
  localparam logic [23:0] HIOUT    = 24'h001000;
  localparam logic [23:0] LOIN     = 24'h002000;
  localparam logic [23:0] LOOUT    = 24'h004000;
  localparam logic [23:0] READ     = 24'h008000;
  localparam logic [23:0] WRITE    = 24'h010000;
  localparam logic [23:0] GRA      = 24'h020000;
  localparam logic [23:0] GRB      = 24'h040000;
  localparam logic [23:0] GRC      = 24'h080000;
  localparam logic [23:0] RIN      = 24'h100000;
  localparam logic [23:0] ROUT     = 24'h200000;
  localparam logic [23:0] BAOUT    = 24'h400000;
  localparam logic [23:0] COUT     = 24'h800000;

  localparam vec_t RESET_VEC = {1'b0, 1'b1, 4'd0, 5'd0, 24'd0};

  logic Clock = 1'b0;
  logic Clear;

  control_sequencer_if bus();

  control_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Scoreboard: expected outputs plus the inputs to apply in the same cycle.
  vec_t  exp_q[$];
  bit    mr_q[$];
  bit    stop_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    fault_now = 1'b0;
  bit    force_stop = 1'b0;
  string cur_name = "";

  function automatic vec_t obs();
    return {bus.Fault, bus.Run, bus.step, bus.alu_op,
            bus.Cout, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
            bus.Write, bus.Read, bus.LOout, bus.LOin, bus.HIout, bus.HIin,
            bus.Zlowout, bus.Zhighout, bus.Zin, bus.Yin, bus.IRin, bus.MDRout,
            bus.MDRin, bus.MARin, bus.IncPC, bus.PCin, bus.PCout};
  endfunction

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int stp, input logic [23:0] s, input logic [4:0] alu,
                      input bit mr, input bit st);
    exp_q.push_back({fault_now, 1'b1, 4'(stp), alu, s});
    mr_q.push_back(mr);
    stop_q.push_back(st);
  endtask

  // One micro-step; a memory step is repeated for each wait cycle before the ready cycle.
  task automatic push_step(input int stp, input logic [23:0] s, input logic [4:0] alu,
                           input bit is_mem, input int waits, input bit is_last,
                           input bit stop_end);
    bit st;
    if (is_mem)
      for (int w = 0; w < waits; w++)
        push(stp, s, alu, 1'b0, force_stop | 1'($urandom_range(0, 1)));
    st = is_last ? stop_end : (force_stop | 1'($urandom_range(0, 1)));
    push(stp, s, alu, is_mem ? 1'b1 : 1'($urandom_range(0, 1)), st);
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++)
      begin
        exp_q.push_back({fault_now, 1'b0, 4'd0, 5'd0, 24'd0});
        mr_q.push_back(1'($urandom_range(0, 1)));
        stop_q.push_back(1'($urandom_range(0, 1)));
      end
  endtask

  task automatic push_fetch(input int tw1);
    push_step(0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
    push_step(1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 1'b1, tw1, 1'b0, 1'b0);
    push_step(2, MDROUT | IRIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic build(input logic [4:0] op, input int tw1, input int tmem,
                       input bit stop_end, output bit halts);
    bit ld, ldi, st, alu, imm, md, un;
    ld  = (op == 5'd0);
    ldi = (op == 5'd1);
    st  = (op == 5'd2);
    alu = (op >= 5'd3) && (op <= 5'd10);
    imm = (op >= 5'd11) && (op <= 5'd13);
    md  = (op == 5'd14) || (op == 5'd15);
    un  = (op == 5'd16) || (op == 5'd17);
    halts = stop_end;
    push_fetch(tw1);
    if (ld || ldi || st) begin
      push_step(3, GRB | BAOUT | YIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
      push_step(4, COUT | ZIN, 5'd3, 1'b0, 0, 1'b0, 1'b0);
      if (ldi) begin
        push_step(5, ZLOWOUT | GRA | RIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
      end else begin
        push_step(5, ZLOWOUT | MARIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
        if (ld) begin
          push_step(6, READ | MDRIN, 5'd0, 1'b1, tmem, 1'b0, 1'b0);
          push_step(7, MDROUT | GRA | RIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
        end else begin
          push_step(6, GRA | ROUT | MDRIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
          push_step(7, WRITE, 5'd0, 1'b1, tmem, 1'b1, stop_end);
        end
      end
    end else if (alu || imm) begin
      push_step(3, GRB | ROUT | YIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
      push_step(4, alu ? (GRC | ROUT | ZIN) : (COUT | ZIN), op, 1'b0, 0, 1'b0, 1'b0);
      push_step(5, ZLOWOUT | GRA | RIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
    end else if (md) begin
      push_step(3, GRA | ROUT | YIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
      push_step(4, GRB | ROUT | ZIN, op, 1'b0, 0, 1'b0, 1'b0);
      push_step(5, ZLOWOUT | LOIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
      push_step(6, ZHIGHOUT | HIIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
    end else if (un) begin
      push_step(3, GRB | ROUT | ZIN, op, 1'b0, 0, 1'b0, 1'b0);
      push_step(4, ZLOWOUT | GRA | RIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
    end else if (op == 5'd24) begin
      push_step(3, HIOUT | GRA | RIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
    end else if (op == 5'd25) begin
      push_step(3, LOOUT | GRA | RIN, 5'd0, 1'b0, 0, 1'b1, stop_end);
    end else if (op == 5'd26) begin
      push_step(3, 24'd0, 5'd0, 1'b0, 0, 1'b1, stop_end);
    end else begin
      // halt and every unassigned opcode stop after an empty T3
      push_step(3, 24'd0, 5'd0, 1'b0, 0, 1'b1, stop_end);
      halts = 1'b1;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_q(input int n);
    int   i;
    vec_t e;
    i = 0;
    while (exp_q.size() > 0 && (n < 0 || i < n)) begin
      bus.MemReady = mr_q.pop_front();
      bus.Stop     = stop_q.pop_front();
      e            = exp_q.pop_front();
      @(negedge Clock);
      check($sformatf("%s c%0d", cur_name, i), obs(), e);
      @(posedge Clock);
      #1;
      i++;
    end
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    fault_now = 1'b0;
    @(negedge Clock);
    check({cur_name, " clear"}, obs(), RESET_VEC);
    @(posedge Clock);
    #1;
    Clear = 1'b0;
  endtask

  task automatic do_instr(input string name, input logic [4:0] op, input int tw1,
                          input int tmem, input bit stop_end, input int halt_cycles);
    bit halts;
    cur_name = name;
    bus.IR = {op, 27'($urandom)};
    build(op, tw1, tmem, stop_end, halts);
    if (halts) push_halt(halt_cycles);
    run_q(-1);
    if (halts) pulse_clear();
  endtask

  task automatic do_timeout();
    cur_name = "timeout";
    bus.IR = {5'd3, 27'($urandom)};
    push_step(0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < WAIT_LIMIT; i++)
      push(1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 1'b0, 1'($urandom_range(0, 1)));
    fault_now = 1'b1;
    push_halt(6);
    run_q(-1);
    pulse_clear();
  endtask

  task automatic do_clear_mid_mul();
    bit halts;
    cur_name = "mul_clr";
    bus.IR = {5'd14, 27'($urandom)};
    build(5'd14, 0, 0, 1'b0, halts);
    run_q(4);
    #2;
    Clear = 1'b1;
    #1;
    check("mul_clr async", obs(), RESET_VEC);
    exp_q.delete();
    mr_q.delete();
    stop_q.delete();
    @(posedge Clock);
    #1;
    Clear = 1'b0;
  endtask

  initial begin
    Clear        = 1'b1;
    bus.IR       = 32'd0;
    bus.MemReady = 1'b0;
    bus.Stop     = 1'b0;
    @(negedge Clock);
    check("reset", obs(), RESET_VEC);
    @(posedge Clock);
    #1;
    Clear = 1'b0;

    do_instr("add", 5'd3, 0, 0, 1'b0, 0);
    do_instr("ld_wait3", 5'd0, 0, 3, 1'b0, 0);
    do_instr("mul", 5'd14, 0, 0, 1'b0, 0);
    do_instr("st", 5'd2, 0, 0, 1'b0, 0);
    do_instr("halt", 5'd27, 0, 0, 1'b0, 20);
    do_timeout();
    do_instr("ld_wait_edge", 5'd0, WAIT_LIMIT - 1, WAIT_LIMIT - 1, 1'b0, 0);
    do_instr("st_wait_edge", 5'd2, WAIT_LIMIT - 1, WAIT_LIMIT - 1, 1'b0, 0);
    do_clear_mid_mul();
    force_stop = 1'b1;
    do_instr("add_stop", 5'd3, 0, 0, 1'b1, 5);
    force_stop = 1'b0;
    do_instr("illegal", 5'd31, 0, 0, 1'b0, 5);

    for (int k = 0; k < 80; k++) begin
      do_instr($sformatf("rnd%0d", k), 5'($urandom_range(0, 31)),
               $urandom_range(0, 3), $urandom_range(0, 4),
               ($urandom_range(0, 7) == 0), 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
